// File: rtl/vending_pkg.sv
// Shared definitions for the vending-machine display/controller path:
// FSM state encoding, BCD digit width and small BCD helpers.
package vending_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  typedef logic [BCD_W-1:0] bcd_t;

  // Out-of-range BCD digits saturate to 9 rather than wrapping.
  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [6:0] bcd_value(input bcd_t tens, input bcd_t ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

endpackage

// File: rtl/sec_countdown_if.sv
// Control, preset and display signals between the vending controller
// and the seconds countdown timer.
interface sec_countdown_if;
  import vending_pkg::*;

  logic clk_1hz;
  logic start;
  logic hold;
  logic clear;
  bcd_t preset_tens;
  bcd_t preset_ones;
  bcd_t sec_tens;
  bcd_t sec_ones;
  logic running;
  logic expired;
  logic expire_pulse;
  logic warn;

  modport master (
    output clk_1hz, start, hold, clear, preset_tens, preset_ones,
    input  sec_tens, sec_ones, running, expired, expire_pulse, warn
  );

  modport slave (
    input  clk_1hz, start, hold, clear, preset_tens, preset_ones,
    output sec_tens, sec_ones, running, expired, expire_pulse, warn
  );

endinterface

// File: rtl/sec_countdown_tick.sv
// Rising-edge strobe for an already-synchronous 1 Hz level; reusable by
// any 1 Hz consumer in the clk_10khz domain.
module tick_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_tick
);

  logic r_prev;

  // Loads even during reset, so a level already high at release is not a tick.
  always_ff @(posedge clk) begin
    r_prev <= i_level;
  end

  assign o_tick = i_level & ~r_prev & ~rst;

endmodule

// File: rtl/sec_countdown.sv
// Two-digit BCD seconds countdown: loads a preset, decrements once per
// 1 Hz tick, and flags expiry to the vending controller.
module sec_countdown
  import vending_pkg::*;
#(
  parameter int unsigned WARN_SEC = 5
) (
  input logic            clk_10khz,
  input logic            rst,
  sec_countdown_if.slave bus
);

  state_e     r_state;
  bcd_t       r_tens;
  bcd_t       r_ones;
  logic       r_expire_pulse;

  logic       w_tick;
  bcd_t       w_preset_tens;
  bcd_t       w_preset_ones;
  logic [6:0] w_count;

  tick_edge_detect u_tick (
    .clk     (clk_10khz),
    .rst     (rst),
    .i_level (bus.clk_1hz),
    .o_tick  (w_tick)
  );

  assign w_preset_tens = bcd_clamp(bus.preset_tens);
  assign w_preset_ones = bcd_clamp(bus.preset_ones);
  assign w_count       = bcd_value(r_tens, r_ones);

  // NOTE: all state here is written with <= so every branch sees the
  // pre-edge values of r_state/r_tens/r_ones regardless of statement order.
  always_ff @(posedge clk_10khz) begin
    if (rst) begin
      r_state        <= IDLE;
      r_tens         <= '0;
      r_ones         <= '0;
      r_expire_pulse <= 1'b0;
    end else begin
      r_expire_pulse <= 1'b0;
      if (bus.clear) begin
        r_state <= IDLE;
        r_tens  <= '0;
        r_ones  <= '0;
      end else if (bus.start) begin
        r_tens <= w_preset_tens;
        r_ones <= w_preset_ones;
        if (w_preset_tens == '0 && w_preset_ones == '0) begin
          r_state        <= EXPIRED;
          // Strobe only on entry, so a held start with preset 00 cannot repeat it.
          r_expire_pulse <= (r_state != EXPIRED);
        end else begin
          r_state <= RUN;
        end
      end else begin
        unique case (r_state)
          RUN: begin
            if (bus.hold) begin
              r_state <= PAUSE;
            end else if (w_tick) begin
              if (w_count == 7'd1) begin
                r_ones         <= '0;
                r_state        <= EXPIRED;
                r_expire_pulse <= 1'b1;
              end else if (w_count != 7'd0) begin
                if (r_ones == '0) begin
                  r_ones <= 4'd9;
                  r_tens <= r_tens - 4'd1;
                end else begin
                  r_ones <= r_ones - 4'd1;
                end
              end
            end
          end
          PAUSE: begin
            if (!bus.hold) r_state <= RUN;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sec_tens     = r_tens;
  assign bus.sec_ones     = r_ones;
  assign bus.expire_pulse = r_expire_pulse;
  assign bus.running      = (r_state == RUN) || (r_state == PAUSE);
  assign bus.expired      = (r_state == EXPIRED);
  assign bus.warn         = bus.running && (w_count <= 7'(WARN_SEC));

endmodule
